// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it fills.
package imem_loader_pkg;

    localparam int IMEM_DEPTH  = 64;
    localparam int IMEM_ADDR_W = 6;

    // A length byte of 0 loads the whole memory.
    localparam bit LEN_ZERO_MEANS_DEPTH = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FIN
    } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Little-endian 8->32 assembler: collects three low bytes and presents the full
// word combinationally alongside the strobe when the fourth byte arrives.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_word_rdy,
    output logic [31:0] o_word
);

    logic [1:0]  r_bcnt;
    logic [23:0] r_lo;

    assign o_word_rdy = i_byte_vld && (r_bcnt == 2'd3);
    assign o_word     = {i_byte, r_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt <= 2'd0;
            r_lo   <= '0;
        end else if (i_clr) begin
            r_bcnt <= 2'd0;
            r_lo   <= '0;
        end else if (i_byte_vld) begin
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
                2'd0:    r_lo[7:0]   <= i_byte;
                2'd1:    r_lo[15:8]  <= i_byte;
                2'd2:    r_lo[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: length byte, little-endian payload words, XOR checksum.
// Writes instruction memory one word at a time and holds the core while busy.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // One extra bit so a full-depth load counts to DEPTH without wrapping.
    localparam int         NW     = ADDR_W + 1;
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    ld_state_t         r_state;
    logic [NW-1:0]     r_wcnt;
    logic [NW-1:0]     r_nwords;
    logic [7:0]        r_xor;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic          w_take;
    logic          w_active;
    logic          w_len_big;
    logic [NW-1:0] w_len;
    logic [NW-1:0] w_wcnt_nxt;
    logic          w_to_fin;
    logic          w_word_rdy;
    logic [31:0]   w_word;

    // A byte presented alongside abort is dropped, never half-consumed.
    assign w_take     = i_in_valid && r_in_ready && !i_abort;
    assign w_active   = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_len_big  = {1'b0, i_in_data} > DEPTH9;
    assign w_len      = (LEN_ZERO_MEANS_DEPTH && i_in_data == 8'd0) ? NW'(DEPTH) : NW'(i_in_data);
    assign w_wcnt_nxt = r_wcnt + NW'(1);
    assign w_to_fin   = w_active && (i_abort || (w_take &&
                        (((r_state == S_LEN) && w_len_big) || (r_state == S_CSUM))));

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      ((r_state == S_IDLE) && i_start),
        .i_byte_vld (w_take && (r_state == S_DATA)),
        .i_byte     (i_in_data),
        .o_word_rdy (w_word_rdy),
        .o_word     (w_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_nwords    <= '0;
            r_xor       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_err      <= 1'b0;
                    r_wcnt     <= '0;
                    r_xor      <= '0;
                    r_busy     <= 1'b1;
                    r_in_ready <= 1'b1;
                    r_state    <= S_LEN;
                end
                S_LEN, S_DATA, S_CSUM: begin
                    if (i_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else if (w_take) begin
                        if (r_state == S_LEN) begin
                            if (w_len_big) begin
                                r_err   <= 1'b1;
                                r_state <= S_FIN;
                            end else begin
                                r_nwords <= w_len;
                                r_state  <= S_DATA;
                            end
                        end else if (r_state == S_DATA) begin
                            r_xor <= r_xor ^ i_in_data;
                            if (w_word_rdy) begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_wcnt[ADDR_W-1:0];
                                r_mem_wdata <= w_word;
                                r_wcnt      <= w_wcnt_nxt;
                                if (w_wcnt_nxt == r_nwords) r_state <= S_CSUM;
                            end
                        end else begin
                            if (i_in_data != r_xor) r_err <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                    if (w_to_fin) begin
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_hold  = r_busy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream, e.g. a UART receiver or debug port. It sits between the byte source and the instruction memory's write port, and holds the core in reset while a program is loading. It parses a framed image (length, little-endian payload words, XOR checksum), issues one word write per four bytes and reports completion and error status.

## Interface
- `DEPTH`, 64: instruction memory depth in 32-bit words.
- `ADDR_W`, 6: word-index width, equal to clog2(`DEPTH`).
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: begin a load; sampled only in IDLE.
- `abort`  in  1: cancel the load in progress.
- `in_valid`  in  1: byte-source valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_we`  out  1: word write strobe, one cycle per word.
- `mem_addr`  out  `ADDR_W`: word index. The memory read side indexes with byte address bits [7:2], so index k is byte address 4k.
- `mem_wdata`  out  32: assembled word.
- `cpu_hold`  out  1: keep the core in reset.
- `busy`  out  1: not in IDLE.
- `done`  out  1: one-cycle pulse at the end of every load attempt.
- `err`  out  1: status of the last load; sticky until the next accepted `start`.

## Operation
- **States:** IDLE, LEN, DATA, CSUM, FIN.
- **Byte transfer:** a byte moves only when `in_valid && in_ready`.
- **`in_ready`:** 1 in LEN, DATA and CSUM; 0 in IDLE and FIN.
- **IDLE:** when `start`=1:
  - clear `err`, the word counter, the byte counter and the running XOR;
  - go to LEN.
- **LEN:** the accepted byte is N, the word count.
  - N=0 means `DEPTH` words.
  - If N>`DEPTH`: set `err` and go to FIN with no writes.
  - Otherwise go to DATA.
- **DATA:** bytes are little-endian. Byte j of a word goes to `mem_wdata[8j+7:8j]`. Every payload byte is XORed into the running checksum.
  - On the 4th byte of a word (byte counter 3):
    - next cycle `mem_we`=1, `mem_addr`=word counter, `mem_wdata`=assembled word;
    - the word counter then increments.
  - After word N-1 has been written, go to CSUM.
- **CSUM:** compare the accepted byte against the running XOR.
  - Mismatch sets `err`. Words already written stay written.
  - Go to FIN.
- **FIN:** `done`=1 for exactly this cycle, then go to IDLE.
- **`abort`:**
  - In LEN, DATA or CSUM: set `err` and go to FIN. A byte presented in the same cycle is discarded.
  - In IDLE: ignored.
- **`start` outside IDLE:** ignored.
- **Byte counter:** 2 bits, wraps 3→0. The word counter is `ADDR_W`+1 bits so N=`DEPTH` completes without aliasing.
- **Stalls:** `in_valid`=0 at any point stalls without timeout. Assembly resumes on the next accepted byte.

## Timing
- **Reset values:** `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_hold`, `busy`, `done` and `err` are all 0; state is IDLE.
- **Write latency:** `mem_we` rises the cycle after the 4th byte is accepted. All memory outputs are registered.
- **Throughput:** back-to-back bytes are accepted every cycle. A byte accepted in the same cycle as `mem_we` is legal.
- **`cpu_hold` and `busy`:** both are 1 from the cycle after `start` is accepted through the `done` cycle inclusive, and 0 the following cycle.
- **`err`:** valid from the `done` cycle onward.
- **Minimum frame:** N=1 completes in 8 cycles from `start`: one start cycle, 6 bytes (length, 4 payload, checksum), one FIN cycle.
- **`rst` mid-load:** immediately returns to reset values. A partial word is never written.

## Structure
- Shared package holds:
  - the state enum;
  - `IMEM_DEPTH`=64 and `IMEM_ADDR_W`=6, also used by the memory;
  - `LEN_ZERO_MEANS_DEPTH`.
- Sub-module `byte_word_packer` handles the 8→32 little-endian assembly, byte counter and word-ready strobe. The FSM, counters and checksum stay in `imem_loader`.

## Test plan
- **Single word.** Stimulus: start, then bytes 01, 13,00,00,00, 13. Required: one write `mem_addr`=0, `mem_wdata`=0x00000013; `done` pulse; `err`=0; `cpu_hold` low the cycle after `done`.
- **Full memory.** Stimulus: N=00, then 256 payload bytes giving word k = 0xA5A50000+k, correct checksum. Required: 64 writes at addresses 0..63 in order; `err`=0.
- **Bad checksum.** Stimulus: N=02 with a checksum byte of XOR^0xFF. Required: 2 writes occur, then `done` with `err`=1.
- **Length overflow.** Stimulus: N=0x41. Required: no `mem_we`; `done` one cycle after the length byte; `err`=1.
- **Abort and reset mid-load.** Stimulus: `abort` after 6 payload bytes. Required: exactly 1 write, `done` with `err`=1. Separately, `rst` asserted mid-word: all outputs are 0 immediately and no write occurs.
- **Flow control.** Stimulus: random `in_valid` gaps; `start` pulsed while busy. Required: writes identical to the gap-free run; the extra `start` has no effect.
